pfa_serial_adder_ctrl: RTL and testbench
========================================

// Module: pfa_serial_adder_ctrl
// PURPOSE
//   Bit-serial add/subtract sequencer built around one 1-bit propagate/generate/sum cell.
//   Latches two WIDTH-bit operands on start and feeds one bit pair per clock, LSB first.
//   Closes the carry loop externally (c_next = G | P&c) and shifts the sum bits into a result register.
//   Reports sum, carry-out, signed overflow and block P/G for use by a higher-level lookahead stage.
// PARAMETERS
//   WIDTH   8   operand/result width in bits (>=2)
// PORTS
//   clk        in   1      single system clock, rising edge
//   rst        in   1      synchronous, active-high reset
//   start      in   1      request; accepted only in IDLE
//   sub        in   1      0: a+b+cin; 1: a-b (b inverted, cin forced 1); latched with start
//   a          in   WIDTH  operand A, latched with start
//   b          in   WIDTH  operand B, latched with start
//   cin        in   1      carry-in for add; ignored when sub=1
//   busy       out  1      high in RUN and DONE
//   done       out  1      one-cycle pulse, results valid
//   sum        out  WIDTH  result, held until next accepted start
//   cout       out  1      carry out of MSB (sub: 1 = no borrow)
//   ovf        out  1      signed overflow = carry into MSB ^ carry out of MSB
//   grp_p      out  1      AND over all bit propagates (p_i = a_i | b'_i)
//   grp_g      out  1      block generate: ripple of g_i | p_i&gg with gg starting at 0
// BEHAVIOUR
//   - Reset: state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, grp_p=0, grp_g=0, counter=0.
//   - FSM IDLE -> RUN -> DONE -> IDLE.
//     - IDLE: start=1 latches a, b^{WIDTH{sub}}, c = sub ? 1 : cin; sets gp=1, gg=0, cnt=0; next state RUN.
//     - RUN: each cycle uses bit cnt.
//       - Cell gives p, g, s.
//       - sum[cnt] <= s ^ c, with s = a_i ^ b'_i. Equivalently, the cell's S output with the cell's Cin = c.
//       - c <= g | (p & c); gp <= gp & p; gg <= g | (p & gg); cnt++.
//       - At cnt = WIDTH-1: capture carry-in-to-MSB for ovf; next state DONE.
//     - DONE: done=1 for exactly one cycle; cout, ovf, grp_p, grp_g updated; next state IDLE.
//   - Latency: start sampled at edge t; done high during cycle t+WIDTH+1; the next start is accepted at edge t+WIDTH+2.
//   - start while busy (RUN or DONE) is ignored, not queued; operand inputs may change freely while busy.
//   - sum, cout, ovf, grp_p, grp_g are registered and stable from done until the next accepted start.
//     - In-flight sum bits go to a shadow register and the visible outputs update at DONE only.
//   - rst during RUN/DONE aborts: returns to IDLE, clears all outputs the same cycle, no done pulse.
//   - rst and start high in the same cycle: rst wins.
//   - Counter width is clog2(WIDTH); it never wraps past WIDTH-1 in RUN.
// STRUCTURE
//   - Shared package pfa_pkg: state encoding (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2) and the default WIDTH constant.
//   - One sub-module: pfa_cell.
//     - Combinational 1-bit cell: P = A|B, G = A&B, S = A^B^Cin.
//     - Instantiated once; its Cin is driven by the carry register.
//   - All other logic is in this module: FSM, counter, operand shift registers, carry/gp/gg registers, result registers.
// TESTING (WIDTH=8)
//   1. a=0x3C b=0x5A sub=0 cin=0 -> after 9 cycles done=1: sum=0x96, cout=0, ovf=1, grp_p=0, grp_g=0.
//   2. a=0xFF b=0x01 sub=0 cin=0 -> sum=0x00, cout=1, ovf=0, grp_p=1, grp_g=1.
//   3. a=0x05 b=0x07 sub=1 -> sum=0xFE, cout=0 (borrow), ovf=0. Then a=0x80 b=0x01 sub=1 -> sum=0x7F, cout=1, ovf=1.
//   4. start held high for 20 cycles with changing a/b:
//      - exactly one done per 10 cycles;
//      - each result matches the operands present at the accepting edge.
//   5. rst pulsed at RUN cycle 4:
//      - busy=0 and all outputs 0 the next cycle, and no done pulse;
//      - the next start completes normally.
//   6. Back-to-back operations: start at the first IDLE cycle after done.
//      - Previous sum holds until the new done.
//      - Check 256 random pairs against a reference model.

Source files
------------

// File: rtl/pfa_pkg.sv
// Shared definitions for the bit-serial propagate/generate adder sequencer.
package pfa_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/pfa_cell.sv
// Combinational 1-bit propagate/generate/sum cell.
module pfa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic p,
  output logic g,
  output logic s
);

  assign p = a | b;
  assign g = a & b;
  assign s = a ^ b ^ cin;

endmodule

// File: rtl/pfa_serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer: one pfa_cell, LSB first, carry loop closed by a register.
// Results (sum, cout, ovf, block P/G) become visible together in the single DONE cycle.
module pfa_serial_adder_ctrl
  import pfa_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             grp_p,
  output logic             grp_g
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-1:0] shadow, shadow_next;
  logic [CNT_W-1:0] cnt;
  logic             c, gp, gg;
  logic             cell_p, cell_g, cell_s;
  logic             c_next;
  logic             accept, last_bit;

  pfa_cell u_cell (
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .cin (c),
    .p   (cell_p),
    .g   (cell_g),
    .s   (cell_s)
  );

  assign c_next   = cell_g | (cell_p & c);
  assign accept   = (state == ST_IDLE) && start;
  assign last_bit = (state == ST_RUN) && (cnt == CNT_LAST);

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next  = state;
    shadow_next = shadow;
    shadow_next[cnt] = cell_s;
    unique case (state)
      ST_IDLE: if (start)    state_next = ST_RUN;
      ST_RUN:  if (last_bit) state_next = ST_DONE;
      ST_DONE:               state_next = ST_IDLE;
      default:               state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      shadow <= '0;
      cnt    <= '0;
      c      <= 1'b0;
      gp     <= 1'b0;
      gg     <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      grp_p  <= 1'b0;
      grp_g  <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        a_sh   <= a;
        b_sh   <= b ^ {WIDTH{sub}};
        c      <= sub | cin;
        gp     <= 1'b1;
        gg     <= 1'b0;
        cnt    <= '0;
        shadow <= '0;
      end else if (state == ST_RUN) begin
        a_sh   <= a_sh >> 1;
        b_sh   <= b_sh >> 1;
        c      <= c_next;
        gp     <= gp & cell_p;
        gg     <= cell_g | (cell_p & gg);
        shadow <= shadow_next;
        cnt    <= last_bit ? cnt : cnt + CNT_W'(1);
        // On the MSB, c is the carry into the MSB and c_next the carry out of it.
        if (last_bit) begin
          sum   <= shadow_next;
          cout  <= c_next;
          ovf   <= c ^ c_next;
          grp_p <= gp & cell_p;
          grp_g <= cell_g | (cell_p & gg);
        end
      end
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_pfa_serial_adder_ctrl.sv
// Directed and random checks of the bit-serial adder sequencer at WIDTH=8.
module tb_pfa_serial_adder_ctrl;

  localparam int W = 8;

  typedef struct packed {
    logic [7:0] s;
    logic       co;
    logic       ov;
    logic       gp;
    logic       gg;
  } res_t;

  logic         clk = 1'b0;
  logic         rst, start, sub, cin;
  logic [W-1:0] a, b;
  logic         busy, done, cout, ovf, grp_p, grp_g;
  logic [W-1:0] sum;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] prev_sum = 8'h00;

  pfa_serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf),
    .grp_p (grp_p),
    .grp_g (grp_g)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain 9-bit arithmetic, sign-rule overflow, carry-out with zero carry-in as block G.
  function automatic res_t model(input logic [7:0] ma, input logic [7:0] mb,
                                 input logic ms, input logic mc);
    res_t       r;
    logic [7:0] bb;
    logic [8:0] full, nocarry;
    bb      = ms ? ~mb : mb;
    full    = {1'b0, ma} + {1'b0, bb} + {8'h00, (ms ? 1'b1 : mc)};
    nocarry = {1'b0, ma} + {1'b0, bb};
    r.s  = full[7:0];
    r.co = full[8];
    r.ov = (ma[7] == bb[7]) && (full[7] != ma[7]);
    r.gp = &(ma | bb);
    r.gg = nocarry[8];
    return r;
  endfunction

  // Issues one operation from IDLE, checks latency, sum hold, results and the return to IDLE.
  task automatic do_op(input string tag, input logic [7:0] ta, input logic [7:0] tbv,
                       input logic ts, input logic tc, input res_t e);
    int n;
    bit hold_bad;
    a = ta; b = tbv; sub = ts; cin = tc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = ~ta; b = ~tbv; sub = ~ts;
    n = 1;
    hold_bad = 1'b0;
    while (!done && n < 20) begin
      if (sum !== prev_sum || !busy) hold_bad = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, n, W + 1);
    check({tag, "_hold"}, {31'd0, hold_bad}, 0);
    check({tag, "_sum"}, sum, e.s);
    check({tag, "_cout"}, cout, e.co);
    check({tag, "_ovf"}, ovf, e.ov);
    check({tag, "_grp_p"}, grp_p, e.gp);
    check({tag, "_grp_g"}, grp_g, e.gg);
    prev_sum = e.s;
    @(posedge clk); #1;
    check({tag, "_idle"}, {busy, done}, 2'b00);
  endtask

  initial begin
    logic [17:0] q[$];
    logic [17:0] item;
    res_t        r;
    logic        pre_busy;
    int          dones, accepts;

    rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_grp_p", grp_p, 0);
    check("rst_grp_g", grp_g, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Hand-computed directed vectors: {sum, cout, ovf, grp_p, grp_g}.
    do_op("t1", 8'h3C, 8'h5A, 1'b0, 1'b0, {8'h96, 1'b0, 1'b1, 1'b0, 1'b0});
    do_op("t2", 8'hFF, 8'h01, 1'b0, 1'b0, {8'h00, 1'b1, 1'b0, 1'b1, 1'b1});
    do_op("t3a", 8'h05, 8'h07, 1'b1, 1'b0, {8'hFE, 1'b0, 1'b0, 1'b0, 1'b0});
    do_op("t3b", 8'h80, 8'h01, 1'b1, 1'b1, {8'h7F, 1'b1, 1'b1, 1'b0, 1'b1});
    do_op("cin1", 8'h7F, 8'h00, 1'b0, 1'b1, {8'h80, 1'b0, 1'b1, 1'b0, 1'b0});

    // start held high with operands changing every cycle.
    dones = 0; accepts = 0;
    start = 1'b1; cin = 1'b0;
    for (int i = 0; i < 20; i++) begin
      a   = 8'(i * 37 + 5);
      b   = 8'(i * 91 + 11);
      sub = (i % 4 == 2);
      pre_busy = busy;
      @(posedge clk);
      if (!pre_busy) begin
        q.push_back({sub, cin, a, b});
        accepts++;
      end
      #1;
      if (done) begin
        dones++;
        if (q.size() == 0) begin
          check("held_queue", 0, 1);
        end else begin
          item = q.pop_front();
          r = model(item[15:8], item[7:0], item[17], item[16]);
          check("held_sum", sum, r.s);
          check("held_cout", cout, r.co);
          check("held_ovf", ovf, r.ov);
          prev_sum = r.s;
        end
      end
    end
    start = 1'b0;
    check("held_dones", dones, 2);
    check("held_accepts", accepts, 2);
    check("held_idle", busy, 0);

    // Reset during RUN aborts with no done pulse.
    a = 8'h11; b = 8'h22; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_busy_before", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_outs", {sum, cout, ovf, grp_p, grp_g}, 0);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("abort_no_done", dones, 0);
    prev_sum = 8'h00;

    // rst and start together: reset wins, nothing starts.
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    check("rst_start_busy", busy, 0);
    @(posedge clk); #1;
    check("rst_start_busy2", busy, 0);
    do_op("post_rst", 8'h11, 8'h22, 1'b0, 1'b0, {8'h33, 1'b0, 1'b0, 1'b0, 1'b0});

    // Back-to-back random operations against the reference model.
    for (int i = 0; i < 256; i++) begin
      logic [7:0] ra, rb;
      logic       rs, rc;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      do_op($sformatf("rnd%0d", i), ra, rb, rs, rc, model(ra, rb, rs, rc));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
